// File: rtl/example_sv_pkg.sv
// Shared types and helpers for the example register bank: addresses, register struct,
// read/write/reset helpers, plus the bus master state type and reset mask.
package example_sv_pkg;

    localparam int unsigned example_data_width = 32;
    localparam int unsigned example_addr_width = 4;
    localparam int unsigned example_num_regs   = 9;

    // Registers 5 and 6 have no reset value in the bank.
    localparam logic [example_num_regs-1:0] example_reset_mask = 9'h19F;

    localparam logic [example_addr_width-1:0] example_reg0_addr = 4'd0;
    localparam logic [example_addr_width-1:0] example_reg1_addr = 4'd1;
    localparam logic [example_addr_width-1:0] example_reg2_addr = 4'd2;
    localparam logic [example_addr_width-1:0] example_reg3_addr = 4'd3;
    localparam logic [example_addr_width-1:0] example_reg4_addr = 4'd4;
    localparam logic [example_addr_width-1:0] example_reg5_addr = 4'd5;
    localparam logic [example_addr_width-1:0] example_reg6_addr = 4'd6;
    localparam logic [example_addr_width-1:0] example_reg7_addr = 4'd7;
    localparam logic [example_addr_width-1:0] example_reg8_addr = 4'd8;

    typedef logic [example_data_width-1:0] example_data_t;
    typedef logic [example_addr_width-1:0] example_addr_t;

    typedef struct packed {
        example_data_t reg8;
        example_data_t reg7;
        example_data_t reg6;
        example_data_t reg5;
        example_data_t reg4;
        example_data_t reg3;
        example_data_t reg2;
        example_data_t reg1;
        example_data_t reg0;
    } example_struct_type;

    typedef enum logic [1:0] {IDLE, REQ, RSP} example_bus_master_state_t;

    function automatic example_struct_type reset_example();
        example_struct_type r;
        r      = '0;
        r.reg1 = 32'd1;
        r.reg4 = 32'd12;
        return r;
    endfunction

    function automatic example_data_t read_example(example_addr_t addr, example_struct_type regs);
        example_data_t d;
        case (addr)
            example_reg0_addr: d = regs.reg0;
            example_reg1_addr: d = regs.reg1;
            example_reg2_addr: d = regs.reg2;
            example_reg3_addr: d = regs.reg3;
            example_reg4_addr: d = regs.reg4;
            example_reg5_addr: d = regs.reg5;
            example_reg6_addr: d = regs.reg6;
            example_reg7_addr: d = regs.reg7;
            example_reg8_addr: d = regs.reg8;
            default:           d = '0;
        endcase
        return d;
    endfunction

    function automatic example_struct_type write_example(example_data_t data, example_addr_t addr,
                                                         example_struct_type regs);
        example_struct_type r;
        r = regs;
        case (addr)
            example_reg0_addr: r.reg0 = data;
            example_reg1_addr: r.reg1 = data;
            example_reg2_addr: r.reg2 = data;
            example_reg3_addr: r.reg3 = data;
            example_reg4_addr: r.reg4 = data;
            example_reg5_addr: r.reg5 = data;
            example_reg6_addr: r.reg6 = data;
            example_reg7_addr: r.reg7 = data;
            example_reg8_addr: r.reg8 = data;
            default:           r = regs;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/example_bus_master_shadow.sv
// Shadow copy of the register bank, updated from completed bus cycles.
// Only instantiated when EXAMPLE_BUS_MASTER_SHADOW_EN is defined.
module example_shadow_regs
    import example_sv_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        captureEn,
    input  logic                        captureWrite,
    input  example_addr_t               captureAddr,
    input  example_data_t               wdata,
    input  example_data_t               rdata,
    output example_struct_type          shadowRegs,
    output logic [example_num_regs-1:0] shadowValid
);

    // Unreset bank registers start as zero in the mirror and are flagged unknown.
    function automatic example_struct_type shadowResetValue();
        example_struct_type r;
        r      = reset_example();
        r.reg5 = '0;
        r.reg6 = '0;
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadowRegs  <= shadowResetValue();
            shadowValid <= example_reset_mask;
        end else if (captureEn) begin
            shadowRegs               <= write_example(captureWrite ? wdata : rdata, captureAddr, shadowRegs);
            shadowValid[captureAddr] <= 1'b1;
        end
    end

endmodule

// File: rtl/example_bus_master.sv
// Single-command bus initiator for the example register bank with timeout and range check.
// Define EXAMPLE_BUS_MASTER_SHADOW_EN to add the shadow_regs/shadow_valid mirror outputs.
module example_bus_master
    import example_sv_pkg::*;
#(
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef EXAMPLE_BUS_MASTER_SHADOW_EN
    ,
    output example_struct_type          shadow_regs,
    output logic [example_num_regs-1:0] shadow_valid
`endif
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(example_num_regs - 1);

    example_bus_master_state_t state, stateNext;
    logic [CNT_W-1:0]  toCount, toCountNext, toCountInc;
    logic              timeoutHit, addrInRange;
    logic              busReqNext, busWeNext, rspValidNext, rspErrNext;
    logic [ADDR_W-1:0] busAddrNext;
    logic [DATA_W-1:0] busWdataNext, rspRdataNext;

    assign addrInRange = (cmd_addr <= LAST_ADDR);
    assign toCountInc  = toCount + CNT_W'(1);
    assign timeoutHit  = (TIMEOUT_CYCLES != 0) && (toCountInc == CNT_W'(TIMEOUT_CYCLES));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next-state logic; ack takes priority over a coincident timeout
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (cmd_valid) stateNext = addrInRange ? REQ : RSP;
            REQ:     if (bus_ack || timeoutHit) stateNext = RSP;
            RSP:     if (rsp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Next values for the registered outputs and the timeout counter
    always_comb begin
        busReqNext   = bus_req;
        busWeNext    = bus_we;
        busAddrNext  = bus_addr;
        busWdataNext = bus_wdata;
        rspValidNext = rsp_valid;
        rspRdataNext = rsp_rdata;
        rspErrNext   = rsp_err;
        toCountNext  = toCount;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (addrInRange) begin
                        busReqNext   = 1'b1;
                        busWeNext    = cmd_write;
                        busAddrNext  = cmd_addr;
                        busWdataNext = cmd_wdata;
                    end else begin
                        rspValidNext = 1'b1;
                        rspErrNext   = 1'b1;
                        rspRdataNext = '0;
                    end
                end
            end
            REQ: begin
                if (bus_ack) begin
                    busReqNext   = 1'b0;
                    rspValidNext = 1'b1;
                    rspErrNext   = 1'b0;
                    rspRdataNext = bus_we ? '0 : bus_rdata;
                    toCountNext  = '0;
                end else if (timeoutHit) begin
                    busReqNext   = 1'b0;
                    rspValidNext = 1'b1;
                    rspErrNext   = 1'b1;
                    rspRdataNext = '0;
                    toCountNext  = '0;
                end else begin
                    toCountNext  = toCountInc;
                end
            end
            RSP: begin
                if (rsp_ready) rspValidNext = 1'b0;
            end
            default: begin
                busReqNext   = 1'b0;
                rspValidNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready <= 1'b1;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            toCount   <= '0;
        end else begin
            cmd_ready <= (stateNext == IDLE);
            bus_req   <= busReqNext;
            bus_we    <= busWeNext;
            bus_addr  <= busAddrNext;
            bus_wdata <= busWdataNext;
            rsp_valid <= rspValidNext;
            rsp_rdata <= rspRdataNext;
            rsp_err   <= rspErrNext;
            toCount   <= toCountNext;
        end
    end

`ifdef EXAMPLE_BUS_MASTER_SHADOW_EN
    example_shadow_regs uShadow (
        .clk          (clk),
        .rst          (rst),
        .captureEn    ((state == REQ) && bus_ack),
        .captureWrite (bus_we),
        .captureAddr  (example_addr_t'(bus_addr)),
        .wdata        (example_data_t'(bus_wdata)),
        .rdata        (example_data_t'(bus_rdata)),
        .shadowRegs   (shadow_regs),
        .shadowValid  (shadow_valid)
    );
`endif

endmodule
